// File: rtl/mtx_pkg.sv
// Shared definitions for the multi-tone TX burst scheduler.
// State encoding, default burst geometry and front-panel GPIO layout.
package mtx_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_TX,
    S_GUARD,
    S_DONE
  } state_e;

  localparam int DEF_NSIG  = 8192;
  localparam int DEF_NSYMB = 16;
  localparam int DEF_GUARD = 64;

  localparam int GPIO_BUSY_BIT = 1;
  localparam int GPIO_TOG_BIT  = 2;

  localparam logic [11:0] GPIO_DDR_MASK = 12'h006;

endpackage

// File: rtl/trig_sync_edge.sv
// 2-flop synchroniser plus rising-edge detect for an async trigger.
// Ports: clk, reset_n (async low), din (async in), rise (1-cycle pulse).
module trig_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise
);

  logic s1_q, s2_q, prev_q;
  logic s1_d, s2_d, prev_d;

  always_comb begin
    s1_d   = din;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  assign rise = s2_q & ~prev_q;

endmodule

// File: rtl/mtx_burst_sched.sv
// Burst scheduler: trigger -> NSYMB symbols of NSIG samples, guard gaps.
// Ports: clk/reset_n, sw_trig/sw_abort, fp_gpio_*, ph_base/ph_step,
// tx_ready in; tx_trig/tx_valid/symbN/sigN/ph_start/busy/done/overrun out.
module mtx_burst_sched
  import mtx_pkg::*;
#(
  parameter int PHASE_WIDTH = 24,
  parameter int NSYMB_WIDTH = 16,
  parameter int NSIG        = DEF_NSIG,
  parameter int NSYMB       = DEF_NSYMB,
  parameter int GUARD       = DEF_GUARD,
  parameter int REG_WIDTH   = 12,
  parameter int TRIG_BIT    = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   sw_trig,
  input  logic                   sw_abort,
  input  logic [REG_WIDTH-1:0]   fp_gpio_in,
  output logic [REG_WIDTH-1:0]   fp_gpio_out,
  output logic [REG_WIDTH-1:0]   fp_gpio_ddr,
  input  logic [PHASE_WIDTH-1:0] ph_base,
  input  logic [PHASE_WIDTH-1:0] ph_step,
  input  logic                   tx_ready,
  output logic                   tx_trig,
  output logic                   tx_valid,
  output logic [NSYMB_WIDTH-1:0] symbN,
  output logic [PHASE_WIDTH-1:0] sigN,
  output logic [PHASE_WIDTH-1:0] ph_start,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);

  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;

  localparam logic [PHASE_WIDTH-1:0] SIG_LAST =
    PHASE_WIDTH'(NSIG - 1);
  localparam logic [NSYMB_WIDTH-1:0] SYM_LAST =
    NSYMB_WIDTH'(NSYMB - 1);
  localparam logic [GW-1:0] GRD_LAST = GW'(GUARD - 1);

  // With no guard gap the next symbol starts straight away.
  localparam state_e AFTER_SYM = (GUARD == 0) ? S_TX : S_GUARD;

  state_e                   state_q, state_d;
  logic [NSYMB_WIDTH-1:0]   sym_q, sym_d;
  logic [PHASE_WIDTH-1:0]   sig_q, sig_d;
  logic [PHASE_WIDTH-1:0]   ph_q, ph_d;
  logic [GW-1:0]            gcnt_q, gcnt_d;
  logic                     ovr_q, ovr_d;
  logic                     tog_q, tog_d;

  logic gpio_rise;
  logic trig;
  logic gpio_unused;

  trig_sync_edge u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (fp_gpio_in[TRIG_BIT]),
    .rise    (gpio_rise)
  );

  assign gpio_unused = ^fp_gpio_in;
  assign trig        = gpio_rise | sw_trig;

  always_comb begin
    state_d = state_q;
    sym_d   = sym_q;
    sig_d   = sig_q;
    ph_d    = ph_q;
    gcnt_d  = gcnt_q;
    ovr_d   = ovr_q;
    tog_d   = tog_q;
    // Abort beats everything, including a symbol boundary.
    if (state_q != S_IDLE && sw_abort) begin
      state_d = S_IDLE;
    end else begin
      if (state_q != S_IDLE && trig) ovr_d = 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (trig && !sw_abort) begin
            state_d = S_ARM;
            sym_d   = '0;
            sig_d   = '0;
            ph_d    = ph_base;
            ovr_d   = 1'b0;
          end
        end
        S_ARM: state_d = S_TX;
        S_TX: begin
          if (tx_ready) begin
            if (sig_q != SIG_LAST) begin
              sig_d = sig_q + PHASE_WIDTH'(1);
            end else if (sym_q == SYM_LAST) begin
              // Final sample: counters keep their last values.
              state_d = S_DONE;
            end else begin
              state_d = AFTER_SYM;
              sig_d   = '0;
              sym_d   = sym_q + NSYMB_WIDTH'(1);
              ph_d    = ph_q + ph_step;
              tog_d   = ~tog_q;
              gcnt_d  = '0;
            end
          end
        end
        S_GUARD: begin
          if (gcnt_q == GRD_LAST) state_d = S_TX;
          else gcnt_d = gcnt_q + GW'(1);
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sym_q   <= '0;
      sig_q   <= '0;
      ph_q    <= '0;
      gcnt_q  <= '0;
      ovr_q   <= 1'b0;
      tog_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sym_q   <= sym_d;
      sig_q   <= sig_d;
      ph_q    <= ph_d;
      gcnt_q  <= gcnt_d;
      ovr_q   <= ovr_d;
      tog_q   <= tog_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign tx_trig  = (state_q == S_ARM);
  assign tx_valid = (state_q == S_TX);
  assign done     = (state_q == S_DONE);
  assign symbN    = sym_q;
  assign sigN     = sig_q;
  assign ph_start = ph_q;
  assign overrun  = ovr_q;

  always_comb begin
    fp_gpio_out                = '0;
    fp_gpio_out[GPIO_BUSY_BIT] = busy;
    fp_gpio_out[GPIO_TOG_BIT]  = tog_q;
  end

  assign fp_gpio_ddr = REG_WIDTH'(GPIO_DDR_MASK);

endmodule
